// File: rtl/gemm_sequencer.sv
// Command-driven sequencer for one systolic-array GEMM pass (IDLE/WARMUP/STEADY/DRAIN).
// Latches the SRAM read ranges at accept and reports completion/rejection as single-cycle pulses.
module gemm_sequencer #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 4,
  parameter int CTRL_WIDTH           = 4,
  parameter int WARMUP_CYCLES        = 1,
  parameter int DRAIN_CYCLES         = NUM_ROW + NUM_COL - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_op,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_top_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_top_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_left_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_left_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_down_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cmd_down_end,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int CW = 16;
  localparam logic [CW-1:0] WARM_LD  = CW'(WARMUP_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_STEADY = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   k_q, k_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] top_s_q, top_s_d, top_e_q, top_e_d;
  logic [AW-1:0] left_s_q, left_s_d, left_e_q, left_e_d;
  logic [AW-1:0] down_s_q, down_s_d, down_e_q, down_e_d;

  logic          accept;
  logic          gemm_ok;
  logic [AW-1:0] top_span;
  logic [AW-1:0] left_span;
  logic [AW:0]   k_new;

  assign o_cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign top_span    = i_cmd_top_end - i_cmd_top_start;
  assign left_span   = i_cmd_left_end - i_cmd_left_start;
  assign gemm_ok     = (i_cmd_top_end >= i_cmd_top_start) && (left_span == top_span);
  // Extra bit keeps K = 2^AW representable for a full-depth range.
  assign k_new       = {1'b0, top_span} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    top_s_d  = top_s_q;
    top_e_d  = top_e_q;
    left_s_d = left_s_q;
    left_e_d = left_e_q;
    down_s_d = down_s_q;
    down_e_d = down_e_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (i_cmd_op) begin
            down_s_d = i_cmd_down_start;
            down_e_d = i_cmd_down_end;
            cnt_d    = DRAIN_LD;
            state_d  = S_DRAIN;
          end else if (gemm_ok) begin
            top_s_d  = i_cmd_top_start;
            top_e_d  = i_cmd_top_end;
            left_s_d = i_cmd_left_start;
            left_e_d = i_cmd_left_end;
            down_s_d = i_cmd_down_start;
            down_e_d = i_cmd_down_end;
            k_d      = k_new;
            cnt_d    = WARM_LD;
            state_d  = S_WARMUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WARMUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(k_q - {{AW{1'b0}}, 1'b1});
          state_d = S_STEADY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STEADY: begin
        if (cnt_q == '0) begin
          cnt_d   = DRAIN_LD;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      top_s_q  <= '0;
      top_e_q  <= '0;
      left_s_q <= '0;
      left_e_q <= '0;
      down_s_q <= '0;
      down_e_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      top_s_q  <= top_s_d;
      top_e_q  <= top_e_d;
      left_s_q <= left_s_d;
      left_e_q <= left_e_d;
      down_s_q <= down_s_d;
      down_e_q <= down_e_d;
    end
  end

  assign o_ctrl_state              = CTRL_WIDTH'(state_q);
  assign o_busy                    = (state_q != S_IDLE);
  assign o_done                    = done_q;
  assign o_err                     = err_q;
  assign o_top_sram_rd_start_addr  = top_s_q;
  assign o_top_sram_rd_end_addr    = top_e_q;
  assign o_left_sram_rd_start_addr = left_s_q;
  assign o_left_sram_rd_end_addr   = left_e_q;
  assign o_down_sram_rd_start_addr = down_s_q;
  assign o_down_sram_rd_end_addr   = down_e_q;

endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed and randomized bench for gemm_sequencer against a per-pass expected state list.
module tb_gemm_sequencer;

  localparam int W  = 1;
  localparam int D  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [3:0] ts = '0, te = '0, ls = '0, le = '0, ds = '0, de = '0;
  logic [3:0] ctrl_state;
  logic [3:0] o_ts, o_te, o_ls, o_le, o_ds, o_de;
  logic       busy, done, err;

  gemm_sequencer dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_top_start(ts), .i_cmd_top_end(te),
    .i_cmd_left_start(ls), .i_cmd_left_end(le),
    .i_cmd_down_start(ds), .i_cmd_down_end(de),
    .o_ctrl_state(ctrl_state),
    .o_top_sram_rd_start_addr(o_ts), .o_top_sram_rd_end_addr(o_te),
    .o_left_sram_rd_start_addr(o_ls), .o_left_sram_rd_end_addr(o_le),
    .o_down_sram_rd_start_addr(o_ds), .o_down_sram_rd_end_addr(o_de),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_q[$];
  logic       exp_err;
  logic [3:0] e_ts = '0, e_te = '0, e_ls = '0, e_le = '0, e_ds = '0, e_de = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_addrs();
    chk("top_start", o_ts, e_ts);
    chk("top_end",   o_te, e_te);
    chk("left_start", o_ls, e_ls);
    chk("left_end",  o_le, e_le);
    chk("down_start", o_ds, e_ds);
    chk("down_end",  o_de, e_de);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [3:0] a, b, c, d, e, f);
    cmd_op = op; ts = a; te = b; ls = c; le = d; ds = e; de = f;
    cmd_valid = 1'b1;
  endtask

  // Expected behaviour of one accepted command, from the pass-length rules.
  task automatic model_accept();
    int k;
    exp_q.delete();
    exp_err = 1'b0;
    if (cmd_op) begin
      e_ds = ds; e_de = de;
      for (int i = 0; i < D; i++) exp_q.push_back(3);
    end else if ((int'(te) >= int'(ts)) && (((int'(le) - int'(ls)) & 15) == (int'(te) - int'(ts)))) begin
      e_ts = ts; e_te = te; e_ls = ls; e_le = le; e_ds = ds; e_de = de;
      k = int'(te) - int'(ts) + 1;
      for (int i = 0; i < W; i++) exp_q.push_back(1);
      for (int i = 0; i < k; i++) exp_q.push_back(2);
      for (int i = 0; i < D; i++) exp_q.push_back(3);
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic accept_edge();
    int waited = 0;
    while (!cmd_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept_timeout: observed ready=%0d expected 1", cmd_ready);
    end
    model_accept();
    step();
  endtask

  task automatic check_result();
    if (exp_err) begin
      chk("err_pulse", err, 1);
      chk("rej_state", ctrl_state, 0);
      chk("rej_busy", busy, 0);
      chk("rej_done", done, 0);
      chk_addrs();
      step();
      chk("err_clear", err, 0);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk("state", ctrl_state, exp_q[i]);
        chk("busy", busy, 1);
        chk("ready_busy", cmd_ready, 0);
        chk("done_early", done, 0);
        chk("err_pass", err, 0);
        chk_addrs();
        step();
      end
      chk("end_state", ctrl_state, 0);
      chk("done_pulse", done, 1);
      chk("done_ready", cmd_ready, 1);
      chk("end_busy", busy, 0);
      chk("end_err", err, 0);
      chk_addrs();
    end
  endtask

  task automatic run_cmd(input logic op, input logic [3:0] a, b, c, d, e, f);
    drive(op, a, b, c, d, e, f);
    accept_edge();
    cmd_valid = 1'b0;
    check_result();
    step();
    chk("done_clear", done, 0);
  endtask

  initial begin
    int n_busy;
    #1 rst = 1'b1;
    #1;
    chk("rst_state", ctrl_state, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk_addrs();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // Basic GEMM, illegal ranges, DRAIN-only, full depth.
    run_cmd(1'b0, 4'd0, 4'd3, 4'd4, 4'd7, 4'd8, 4'd11);
    run_cmd(1'b0, 4'd5, 4'd2, 4'd5, 4'd2, 4'd1, 4'd1);
    run_cmd(1'b0, 4'd0, 4'd3, 4'd0, 4'd1, 4'd1, 4'd1);
    run_cmd(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd2, 4'd9);
    chk("drain_keeps_top", o_te, 3);
    drive(1'b0, 4'd0, 4'd15, 4'd0, 4'd15, 4'd3, 4'd4);
    accept_edge();
    cmd_valid = 1'b0;
    n_busy = exp_q.size();
    chk("full_depth_len", n_busy, 24);
    check_result();
    step();

    // Back-to-back: second command held valid through the first pass.
    drive(1'b0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd2);
    accept_edge();
    drive(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    check_result();
    model_accept();
    step();
    cmd_valid = 1'b0;
    check_result();
    step();

    // Asynchronous reset in the third STEADY cycle.
    drive(1'b0, 4'd0, 4'd3, 4'd4, 4'd7, 4'd8, 4'd11);
    accept_edge();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_steady", ctrl_state, 2);
    #2 rst = 1'b1;
    #1;
    e_ts = '0; e_te = '0; e_ls = '0; e_le = '0; e_ds = '0; e_de = '0;
    chk("arst_state", ctrl_state, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 0);
    chk("arst_done", done, 0);
    chk_addrs();
    step();
    chk("arst_hold_done", done, 0);
    rst = 1'b0;
    #1;
    run_cmd(1'b0, 4'd0, 4'd3, 4'd4, 4'd7, 4'd8, 4'd11);

    // Randomized commands, mostly legal.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] a, b, c, d;
      logic       op;
      op = ($urandom_range(0, 3) == 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      d = (($urandom_range(0, 3) != 0)) ? 4'(c + (b - a)) : 4'($urandom_range(0, 15));
      run_cmd(op, a, b, c, d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
